// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter with valid/ready input and framing strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             frame_start_q;
  logic             frame_end_q;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif
  logic             last_bit;
  logic             accept;

  // The outgoing bit is always taken from the leading end of the word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

`ifdef PISO_PARITY_EN
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST);
`endif

  assign in_ready    = !rst && ((state_q == IDLE) || last_bit);
  assign accept      = in_valid && in_ready;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign busy        = (state_q != IDLE);

  // The first bit goes out straight from in_data on the accept edge, so the
  // shift register holds only the not-yet-sent remainder of the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sreg_q        <= '0;
      bit_cnt_q     <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else if (accept) begin
      state_q       <= SHIFT;
      sreg_q        <= shift1(in_data);
      bit_cnt_q     <= '0;
      ser_out_q     <= first_bit(in_data);
      ser_valid_q   <= 1'b1;
      frame_start_q <= 1'b1;
      frame_end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q         <= ^in_data;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (bit_cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_q       <= PARITY;
            ser_out_q     <= par_q;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b1;
`else
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
`endif
          end else begin
            bit_cnt_q     <= bit_cnt_q + CW'(1);
            ser_out_q     <= first_bit(sreg_q);
            sreg_q        <= shift1(sreg_q);
            frame_start_q <= 1'b0;
            frame_end_q   <= (bit_cnt_q == PENULT) && !PAR_EN;
          end
        end
        default: begin
          state_q       <= IDLE;
          bit_cnt_q     <= '0;
          ser_out_q     <= 1'b0;
          ser_valid_q   <= 1'b0;
          frame_start_q <= 1'b0;
          frame_end_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances driven in parallel and
// checked every cycle against a queue-of-frame-bits reference model.
module tb_piso_shift_tx;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;

  logic rdy_m, so_m, sv_m, fs_m, fe_m, bz_m;
  logic rdy_l, so_l, sv_l, fs_l, fe_l, bz_l;

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m),
    .frame_start(fs_m), .frame_end(fe_m), .busy(bz_m));

  piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .ser_out(so_l), .ser_valid(sv_l),
    .frame_start(fs_l), .frame_end(fe_l), .busy(bz_l));

  always #5 clk = ~clk;

  typedef struct packed { logic b; logic s; logic e; } rec_t;
  rec_t qm[$];
  rec_t ql[$];
  int   n_acc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct { logic [W-1:0] word; logic [W-1:0] seq_msb; logic [W-1:0] seq_lsb; } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a word accepted while at most one frame bit is still pending
  // becomes FL queued (bit, start, end) records in send order.
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < FL; i++) begin
      rec_t rm, rl;
      if (i < W) begin
        rm.b = w[W-1-i];
        rl.b = w[i];
      end else begin
        rm.b = ^w;
        rl.b = ^w;
      end
      rm.s = (i == 0);
      rm.e = (i == FL - 1);
      rl.s = rm.s;
      rl.e = rm.e;
      qm.push_back(rm);
      ql.push_back(rl);
    end
  endtask

  task automatic step();
    bit acc;
    acc = in_valid && !rst && (qm.size() <= 1);
    if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (acc) begin
      push_word(in_data);
      n_acc++;
    end
  endtask

  task automatic check_all();
    rec_t em, el;
    logic er;
    em = (qm.size() > 0) ? qm[0] : '0;
    el = (ql.size() > 0) ? ql[0] : '0;
    er = !rst && (qm.size() <= 1);
    chk("msb.ser_out",     so_m,  em.b);
    chk("msb.ser_valid",   sv_m,  qm.size() > 0);
    chk("msb.frame_start", fs_m,  em.s);
    chk("msb.frame_end",   fe_m,  em.e);
    chk("msb.busy",        bz_m,  qm.size() > 0);
    chk("msb.in_ready",    rdy_m, er);
    chk("lsb.ser_out",     so_l,  el.b);
    chk("lsb.ser_valid",   sv_l,  ql.size() > 0);
    chk("lsb.frame_start", fs_l,  el.s);
    chk("lsb.frame_end",   fe_l,  el.e);
    chk("lsb.busy",        bz_l,  ql.size() > 0);
    chk("lsb.in_ready",    rdy_l, er);
  endtask

  task automatic cyc();
    @(posedge clk);
    step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    qm.delete();
    ql.delete();
    #1;
    check_all();
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    logic [W-1:0] gm, gl;
    int base, svc, gaps, k;
    bit dropped;

    tbl[0] = '{8'hA5, 8'b10100101, 8'b10100101};
    tbl[1] = '{8'h01, 8'b00000001, 8'b10000000};
    tbl[2] = '{8'h12, 8'b00010010, 8'b01001000};
    tbl[3] = '{8'hC3, 8'b11000011, 8'b11000011};
    tbl[4] = '{8'hFF, 8'b11111111, 8'b11111111};
    tbl[5] = '{8'h80, 8'b10000000, 8'b00000001};

    #1;
    check_all();
    do_reset();

    // Single words from idle: captured serial order against the table.
    for (int t = 0; t < 6; t++) begin
      in_data  = tbl[t].word;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      in_data  = ~tbl[t].word;
      for (int i = 0; i < W; i++) begin
        gm[W-1-i] = so_m;
        gl[W-1-i] = so_l;
        cyc();
      end
      repeat (FL - W + 1) cyc();
      chk("tbl.seq_msb", gm, tbl[t].seq_msb);
      chk("tbl.seq_lsb", gl, tbl[t].seq_lsb);
    end

    // Back-to-back: in_valid held across FF then 00.
    base = n_acc;
    in_data  = 8'hFF;
    in_valid = 1'b1;
    svc = 0;
    gaps = 0;
    dropped = 0;
    for (int c = 0; c < 2 * FL + 6; c++) begin
      cyc();
      in_data = 8'h00;
      if (n_acc - base >= 2) in_valid = 1'b0;
      if (sv_m) begin
        svc++;
        if (dropped) gaps++;
      end else if (svc > 0) dropped = 1;
    end
    chk("b2b.accepts", n_acc - base, 2);
    chk("b2b.valid_cycles", svc, 2 * FL);
    chk("b2b.gaps", gaps, 0);

    // Reset in the middle of a frame, then a fresh word.
    in_data  = 8'hC3;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (2) cyc();
    do_reset();
    in_data  = 8'h3C;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("rst.fresh_start", fs_m, 1'b1);
    chk("rst.first_bit",   so_m, 1'b0);
    repeat (FL + 1) cyc();

`ifdef PISO_PARITY_EN
    // Parity bit arrives on the (W+1)th cycle together with frame_end.
    in_data  = 8'h07;
    in_valid = 1'b1;
    cyc();
    in_data  = 8'h03;
    repeat (W) cyc();
    chk("par.bit_07", so_m, 1'b1);
    chk("par.end_07", fe_m, 1'b1);
    in_valid = 1'b0;
    repeat (W) cyc();
    chk("par.bit_03", so_m, 1'b0);
    chk("par.end_03", fe_m, 1'b1);
    repeat (2) cyc();
`endif

    // Random handshake traffic: 100 words, bounded cycle budget.
    base = n_acc;
    k = 0;
    while ((n_acc - base) < 100 && k < 5000) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      cyc();
      k++;
    end
    in_valid = 1'b0;
    chk("rand.accepts", n_acc - base, 100);
    repeat (FL + 2) cyc();
    chk("rand.drained", qm.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
